// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: turns PS/2 movement packets into a clamped or wrapped cursor position,
// a saturating wheel count, button edge masks and a sticky IRQ, through a 2-stage pipeline.
module mouse_position_tracker #(
    parameter int COORD_WIDTH = 10,
    parameter int LIMIT_X = 640,
    parameter int LIMIT_Y = 480,
    parameter int HAS_WHEEL = 1,
    parameter int WHEEL_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PKT_VALID,
    input  logic [7:0]             STATUS,
    input  logic [7:0]             DX,
    input  logic [7:0]             DY,
    input  logic [3:0]             DZ,
    input  logic [1:0]             SPEED,
    input  logic                   WRAP_MODE,
    input  logic                   CENTRE,
    input  logic                   IRQ_ACK,
    output logic [COORD_WIDTH-1:0] POS_X,
    output logic [COORD_WIDTH-1:0] POS_Y,
    output logic [WHEEL_WIDTH-1:0] POS_Z,
    output logic [2:0]             BUTTONS,
    output logic [2:0]             BTN_PRESS,
    output logic [2:0]             BTN_RELEASE,
    output logic                   UPDATE,
    output logic                   IRQ
);
    localparam int NW = (COORD_WIDTH + 2 > 12) ? COORD_WIDTH + 2 : 12;
    localparam logic [COORD_WIDTH-1:0] CX = COORD_WIDTH'(LIMIT_X / 2);
    localparam logic [COORD_WIDTH-1:0] CY = COORD_WIDTH'(LIMIT_Y / 2);
    localparam logic signed [NW-1:0] LXN = NW'(LIMIT_X);
    localparam logic signed [NW-1:0] LXM = NW'(LIMIT_X - 1);
    localparam logic signed [NW-1:0] LYN = NW'(LIMIT_Y);
    localparam logic signed [NW-1:0] LYM = NW'(LIMIT_Y - 1);
    localparam logic [WHEEL_WIDTH-1:0] ZMAX = {1'b0, {(WHEEL_WIDTH-1){1'b1}}};
    localparam logic [WHEEL_WIDTH-1:0] ZMIN = {1'b1, {(WHEEL_WIDTH-1){1'b0}}};

    logic                   s1Valid, s1Wrap;
    logic signed [10:0]     s1Dx, s1Dy, scX, scY;
    logic [3:0]             s1Dz;
    logic [2:0]             s1Btn;
    logic [COORD_WIDTH-1:0] nextX, nextY;
    logic [WHEEL_WIDTH-1:0] nextZ;
    logic [WHEEL_WIDTH:0]   zSum;
    logic                   changed, unusedStatus;

    function automatic logic signed [10:0] scale(input logic ovf, input logic sign,
                                                 input logic [7:0] mag, input logic [1:0] spd);
        logic signed [10:0] v;
        v = ovf ? (sign ? -11'sd256 : 11'sd255) : {{3{sign}}, mag};
        return spd == 2'd0 ? v >>> 1 : spd == 2'd1 ? v : spd == 2'd2 ? v <<< 1 : v <<< 2;
    endfunction

    // Wrap mode pre-saturates the delta so a single +/-limit correction always lands in range.
    function automatic logic [COORD_WIDTH-1:0] step(input logic [COORD_WIDTH-1:0] pos,
                                                    input logic signed [10:0] d, input logic wrap,
                                                    input logic signed [NW-1:0] top,
                                                    input logic signed [NW-1:0] lim);
        logic signed [NW-1:0] dl, s;
        dl = {{(NW-11){d[10]}}, d};
        if (wrap) dl = dl > top ? top : dl < -top ? -top : dl;
        s = $signed({{(NW-COORD_WIDTH){1'b0}}, pos}) + dl;
        if (wrap) s = s[NW-1] ? s + lim : s >= lim ? s - lim : s;
        else s = s[NW-1] ? '0 : s > top ? top : s;
        return s[COORD_WIDTH-1:0];
    endfunction

    always_comb begin
        unusedStatus = STATUS[3];
        scX = scale(STATUS[6], STATUS[4], DX, SPEED);
        scY = scale(STATUS[7], STATUS[5], DY, SPEED);
        nextX = step(POS_X, s1Dx, s1Wrap, LXM, LXN);
        nextY = step(POS_Y, s1Dy, s1Wrap, LYM, LYN);
        zSum = {POS_Z[WHEEL_WIDTH-1], POS_Z} + {{(WHEEL_WIDTH-3){s1Dz[3]}}, s1Dz};
        nextZ = HAS_WHEEL == 0 ? '0 :
                zSum[WHEEL_WIDTH] != zSum[WHEEL_WIDTH-1] ? (zSum[WHEEL_WIDTH] ? ZMIN : ZMAX) :
                zSum[WHEEL_WIDTH-1:0];
        changed = nextX != POS_X || nextY != POS_Y || nextZ != POS_Z || s1Btn != BUTTONS;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1Valid <= 1'b0;
            s1Wrap <= 1'b0;
            s1Dx <= '0;
            s1Dy <= '0;
            s1Dz <= '0;
            s1Btn <= '0;
            POS_X <= CX;
            POS_Y <= CY;
            POS_Z <= '0;
            BUTTONS <= '0;
            BTN_PRESS <= '0;
            BTN_RELEASE <= '0;
            UPDATE <= 1'b0;
            IRQ <= 1'b0;
        end else begin
            s1Valid <= PKT_VALID;
            if (PKT_VALID) begin
                s1Wrap <= WRAP_MODE;
                s1Dx <= scX;
                s1Dy <= scY;
                s1Dz <= DZ;
                s1Btn <= STATUS[2:0];
            end
            UPDATE <= s1Valid;
            BTN_PRESS <= s1Valid ? s1Btn & ~BUTTONS : 3'b0;
            BTN_RELEASE <= s1Valid ? ~s1Btn & BUTTONS : 3'b0;
            if (s1Valid) BUTTONS <= s1Btn;
            POS_X <= CENTRE ? CX : s1Valid ? nextX : POS_X;
            POS_Y <= CENTRE ? CY : s1Valid ? nextY : POS_Y;
            POS_Z <= CENTRE ? '0 : s1Valid ? nextZ : POS_Z;
            IRQ <= CENTRE | (s1Valid & changed) | (IRQ & ~IRQ_ACK);
        end
    end
endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker: directed checks of position, clamp/wrap, speed, buttons,
// wheel saturation, CENTRE/IRQ_ACK/RESET interactions; a second instance has no wheel.
module tb_mouse_position_tracker;
    logic CLK = 0, RESET, PKT_VALID, WRAP_MODE, CENTRE, IRQ_ACK;
    logic [7:0] STATUS, DX, DY;
    logic [3:0] DZ;
    logic [1:0] SPEED;
    logic [9:0] POS_X, POS_Y, nwX, nwY;
    logic [7:0] POS_Z, nwZ;
    logic [2:0] BUTTONS, BTN_PRESS, BTN_RELEASE, nwBtn, nwPress, nwRel;
    logic UPDATE, IRQ, nwUpd, nwIrq;
    int checks = 0, errors = 0;

    mouse_position_tracker dut (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS), .DX(DX), .DY(DY),
        .DZ(DZ), .SPEED(SPEED), .WRAP_MODE(WRAP_MODE), .CENTRE(CENTRE), .IRQ_ACK(IRQ_ACK),
        .POS_X(POS_X), .POS_Y(POS_Y), .POS_Z(POS_Z), .BUTTONS(BUTTONS), .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE), .UPDATE(UPDATE), .IRQ(IRQ)
    );

    mouse_position_tracker #(.HAS_WHEEL(0)) noWheel (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS), .DX(DX), .DY(DY),
        .DZ(DZ), .SPEED(SPEED), .WRAP_MODE(WRAP_MODE), .CENTRE(CENTRE), .IRQ_ACK(IRQ_ACK),
        .POS_X(nwX), .POS_Y(nwY), .POS_Z(nwZ), .BUTTONS(nwBtn), .BTN_PRESS(nwPress),
        .BTN_RELEASE(nwRel), .UPDATE(nwUpd), .IRQ(nwIrq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] z);
        STATUS = st; DX = x; DY = y; DZ = z; PKT_VALID = 1;
        @(negedge CLK);
        PKT_VALID = 0;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1; PKT_VALID = 0; WRAP_MODE = 0; CENTRE = 0; IRQ_ACK = 0;
        STATUS = 0; DX = 0; DY = 0; DZ = 0; SPEED = 1;
        repeat (2) @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
        chk("rst_x", POS_X, 320);
        chk("rst_y", POS_Y, 240);
        chk("rst_z", POS_Z, 0);
        chk("rst_btn", BUTTONS, 0);
        chk("rst_upd", UPDATE, 0);
        chk("rst_irq", IRQ, 0);
        // basic move with explicit latency
        STATUS = 8'h00; DX = 10; DY = 5; PKT_VALID = 1;
        @(negedge CLK);
        PKT_VALID = 0;
        chk("lat_upd_early", UPDATE, 0);
        chk("lat_x_early", POS_X, 320);
        @(negedge CLK);
        chk("move_x", POS_X, 330);
        chk("move_y", POS_Y, 245);
        chk("move_upd", UPDATE, 1);
        chk("move_irq", IRQ, 1);
        IRQ_ACK = 1;
        @(negedge CLK);
        IRQ_ACK = 0;
        chk("ack_irq", IRQ, 0);
        chk("upd_one_cycle", UPDATE, 0);
        // recentre then clamp at left edge
        CENTRE = 1;
        @(negedge CLK);
        CENTRE = 0;
        chk("centre_x", POS_X, 320);
        chk("centre_y", POS_Y, 240);
        chk("centre_irq", IRQ, 1);
        send(8'h10, 8'h00, 0, 0);
        chk("clamp1_x", POS_X, 64);
        send(8'h10, 8'h00, 0, 0);
        chk("clamp2_x", POS_X, 0);
        send(8'h10, 8'h00, 0, 0);
        chk("clamp3_x", POS_X, 0);
        send(8'h40, 8'h12, 0, 0);
        chk("xovf_x", POS_X, 255);
        chk("xovf_y", POS_Y, 240);
        send(8'h00, 8'd255, 0, 0);
        send(8'h00, 8'd120, 0, 0);
        chk("pre_wrap_x", POS_X, 630);
        // wrap mode and speed settings
        WRAP_MODE = 1;
        send(8'h00, 8'd20, 0, 0);
        chk("wrap_hi_x", POS_X, 10);
        SPEED = 0;
        send(8'h10, 8'hFF, 0, 0);
        chk("half_neg1_x", POS_X, 9);
        SPEED = 1;
        send(8'h10, 8'hF6, 0, 0);
        chk("wrap_lo_x", POS_X, 639);
        WRAP_MODE = 0;
        SPEED = 3;
        send(8'h10, 8'hCE, 0, 0);
        chk("x4_x", POS_X, 439);
        SPEED = 2;
        send(8'h00, 0, 8'd10, 0);
        chk("x2_y", POS_Y, 260);
        SPEED = 1;
        // buttons
        send(8'h01, 0, 0, 0);
        chk("b1_press", BTN_PRESS, 3'b001);
        chk("b1_rel", BTN_RELEASE, 3'b000);
        chk("b1_btn", BUTTONS, 3'b001);
        send(8'h02, 0, 0, 0);
        chk("b2_press", BTN_PRESS, 3'b010);
        chk("b2_rel", BTN_RELEASE, 3'b001);
        chk("b2_btn", BUTTONS, 3'b010);
        @(negedge CLK);
        chk("b_press_clear", BTN_PRESS, 0);
        chk("b_rel_clear", BTN_RELEASE, 0);
        // back-to-back wheel packets
        STATUS = 8'h02; DX = 1; DY = 0; DZ = 4'd7;
        for (int i = 0; i < 20; i++) begin
            PKT_VALID = 1;
            @(negedge CLK);
        end
        PKT_VALID = 0;
        @(negedge CLK);
        chk("wheel_sat_z", POS_Z, 127);
        chk("b2b_x", POS_X, 459);
        chk("nowheel_z", nwZ, 0);
        chk("nowheel_x", nwX, 459);
        send(8'h02, 0, 0, 4'h8);
        chk("wheel_dec_z", POS_Z, 119);
        // CENTRE coincident with commit
        STATUS = 8'h04; DX = 5; DY = 0; DZ = 0; PKT_VALID = 1;
        @(negedge CLK);
        PKT_VALID = 0; CENTRE = 1;
        @(negedge CLK);
        CENTRE = 0;
        chk("cc_x", POS_X, 320);
        chk("cc_y", POS_Y, 240);
        chk("cc_z", POS_Z, 0);
        chk("cc_btn", BUTTONS, 3'b100);
        chk("cc_press", BTN_PRESS, 3'b100);
        chk("cc_rel", BTN_RELEASE, 3'b010);
        chk("cc_upd", UPDATE, 1);
        IRQ_ACK = 1;
        @(negedge CLK);
        IRQ_ACK = 0;
        chk("ack2_irq", IRQ, 0);
        send(8'h04, 0, 0, 0);
        chk("nochg_upd", UPDATE, 1);
        chk("nochg_irq", IRQ, 0);
        // IRQ_ACK coincident with IRQ set
        STATUS = 8'h04; DX = 3; PKT_VALID = 1;
        @(negedge CLK);
        PKT_VALID = 0; IRQ_ACK = 1;
        @(negedge CLK);
        IRQ_ACK = 0;
        chk("ackset_irq", IRQ, 1);
        chk("ackset_x", POS_X, 323);
        // RESET one cycle after PKT_VALID
        STATUS = 8'h01; DX = 50; PKT_VALID = 1;
        @(negedge CLK);
        PKT_VALID = 0; RESET = 1;
        @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
        chk("rstmid_upd", UPDATE, 0);
        chk("rstmid_x", POS_X, 320);
        chk("rstmid_y", POS_Y, 240);
        chk("rstmid_btn", BUTTONS, 0);
        chk("rstmid_irq", IRQ, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
